// File: rtl/img_crypt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_crypt_pkg
// Brief    : Shared definitions for the image encrypt/decrypt datapath:
//            default key, frame geometry, keystream function and the
//            sweep FSM state encoding.
// Options  : ROLLING_KEY_EN - mixes the low address byte into the keystream.
// Revision : 1.0 - initial release
// ============================================================================
package img_crypt_pkg;

    localparam logic [7:0] c_KEY_DEFAULT   = 8'b10110011;
    localparam int         c_ADDR_W        = 15;
    localparam int         c_DEPTH_DEFAULT = 19200;

`ifdef ROLLING_KEY_EN
    localparam bit c_ROLLING_KEY = 1'b1;
`else
    localparam bit c_ROLLING_KEY = 1'b0;
`endif

    // Frame sweep states, shared by both ends of the crypt path.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } crypt_state_t;

    // Keystream byte for one address. The base stream is KEY ^ (KEY << 4)
    // kept to 8 bits; the rolling variant folds in the low address byte so
    // that identical plaintext bytes do not produce identical ciphertext.
    function automatic logic [7:0] ks(input logic [7:0] key, input logic [7:0] addr_lo);
        logic [7:0] base;
        base = key ^ {key[3:0], 4'h0};
        return c_ROLLING_KEY ? (base ^ addr_lo) : base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keystream_gen.sv
`default_nettype none
// ============================================================================
// Module   : keystream_gen
// Brief    : Produces the keystream byte for a given buffer address. Used on
//            both the encrypt and decrypt sides so they stay bit-identical.
// Options  : ROLLING_KEY_EN - per-address keystream (KS ^ addr[7:0]);
//            undefined gives a constant keystream.
// Revision : 1.0 - initial release
// ============================================================================
module keystream_gen
    import img_crypt_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic [7:0]        key,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        ks_byte
);

    logic [7:0] w_addr_lo;
    // Upper address bits never influence the keystream; folded here so the
    // full address bus is visibly consumed.
    logic       w_unused_addr_hi;

    generate
        if (ADDR_W > 8) begin : g_addr_wide
            assign w_addr_lo        = addr[7:0];
            assign w_unused_addr_hi = ^addr[ADDR_W-1:8];
        end else begin : g_addr_narrow
            assign w_addr_lo        = 8'(addr);
            assign w_unused_addr_hi = 1'b0;
        end
    endgenerate

    assign ks_byte = img_crypt_pkg::ks(key, w_addr_lo);

endmodule
`default_nettype wire

// File: rtl/encrypter.sv
`default_nettype none
// ============================================================================
// Module   : encrypter
// Brief    : Sweeps a plaintext frame buffer (1-cycle registered-read BRAM),
//            XORs each byte with the shared keystream and writes ciphertext
//            into the encrypted-image BRAM. One full pass per start pulse,
//            one byte per cycle, fixed 2-cycle read-to-write latency.
// Options  : ROLLING_KEY_EN - per-address keystream (see keystream_gen).
// Revision : 1.0 - initial release
// ============================================================================
module encrypter
    import img_crypt_pkg::*;
#(
    parameter logic [7:0] KEY    = c_KEY_DEFAULT,
    parameter int         DEPTH  = c_DEPTH_DEFAULT,   // 1..32768
    parameter int         ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        plain_data,
    output logic [ADDR_W-1:0] read_addr,
    output logic [7:0]        encrypted_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_en,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    crypt_state_t      r_state;
    crypt_state_t      w_state_nxt;

    logic [ADDR_W-1:0] r_read_addr;

    // Read-return stage: tracks which address the BRAM is answering.
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_addr;

    // Write stage registers, driven straight onto the output ports.
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_enc_data;

    logic              w_accept;
    logic              w_advance;
    logic              w_last_write;
    logic              w_busy;
    logic              w_done;
    logic [7:0]        w_ks;

    // The keystream is selected by the address whose data is arriving this
    // cycle, which is exactly the address that will be written next edge.
    keystream_gen #(
        .ADDR_W (ADDR_W)
    ) u_keystream_gen (
        .key     (KEY),
        .addr    (r_rd_addr),
        .ks_byte (w_ks)
    );

    assign w_last_write = r_wr_en && (r_wr_addr == c_LAST_ADDR);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control decode. busy covers issue and drain; done
    // is a single-cycle state, so busy drops exactly when done rises.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_read_addr == c_LAST_ADDR) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_last_write) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read address: restarts at 0 on an accepted start, steps once per RUN
    // cycle and otherwise holds, so it parks on DEPTH-1 after a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_addr <= '0;
        end else if (w_accept) begin
            r_read_addr <= '0;
        end else if (w_advance) begin
            r_read_addr <= r_read_addr + ADDR_W'(1);
        end
    end

    // Read-return stage: every RUN cycle has an issued address in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
        end else begin
            r_rd_valid <= (r_state == ST_RUN);
            r_rd_addr  <= r_read_addr;
        end
    end

    // Write stage: encrypt the returning byte; address and data hold their
    // last values between passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_enc_data <= '0;
        end else begin
            r_wr_en <= r_rd_valid;
            if (r_rd_valid) begin
                r_wr_addr  <= r_rd_addr;
                r_enc_data <= plain_data ^ w_ks;
            end
        end
    end

    assign read_addr      = r_read_addr;
    assign write_addr     = r_wr_addr;
    assign encrypted_data = r_enc_data;
    assign write_en       = r_wr_en;
    assign busy           = w_busy;
    assign done           = w_done;

endmodule
`default_nettype wire

// File: tb/tb_encrypter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_encrypter
// Brief    : Self-checking bench for encrypter. Three instances (DEPTH 4,
//            full frame, 1) share one plaintext memory and one reset.
// Options  : ROLLING_KEY_EN - switches the reference keystream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encrypter;

    localparam logic [7:0] c_KEY = 8'b10110011;
    localparam int         c_AW  = 15;
    localparam int         c_D4  = 4;
    localparam int         c_DF  = 19200;
    localparam int         c_D1  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem [0:32767];
    int         cycle = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic            s_start = 1'b0, f_start = 1'b0, o_start = 1'b0;
    logic [7:0]      s_plain, f_plain, o_plain;
    logic [c_AW-1:0] s_raddr, f_raddr, o_raddr;
    logic [c_AW-1:0] s_waddr, f_waddr, o_waddr;
    logic [7:0]      s_edata, f_edata, o_edata;
    logic            s_we, f_we, o_we;
    logic            s_busy, f_busy, o_busy;
    logic            s_done, f_done, o_done;

    // Write/done logs, appended only by the monitor.
    logic [c_AW-1:0] s_wa[$], f_wa[$], o_wa[$];
    logic [7:0]      s_wd[$], f_wd[$], o_wd[$];
    int              s_wt[$], o_wt[$];
    int              s_dn = 0, f_dn = 0, o_dn = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Registered-read BRAM models.
    always @(posedge clk) begin
        s_plain <= mem[s_raddr];
        f_plain <= mem[f_raddr];
        o_plain <= mem[o_raddr];
    end

    // Monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (s_we === 1'b1) begin s_wa.push_back(s_waddr); s_wd.push_back(s_edata); s_wt.push_back(cycle); end
        if (f_we === 1'b1) begin f_wa.push_back(f_waddr); f_wd.push_back(f_edata); end
        if (o_we === 1'b1) begin o_wa.push_back(o_waddr); o_wd.push_back(o_edata); o_wt.push_back(cycle); end
        if (s_done === 1'b1) s_dn <= s_dn + 1;
        if (f_done === 1'b1) f_dn <= f_dn + 1;
        if (o_done === 1'b1) o_dn <= o_dn + 1;
    end

    encrypter #(.KEY(c_KEY), .DEPTH(c_D4), .ADDR_W(c_AW)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .plain_data(s_plain),
        .read_addr(s_raddr), .encrypted_data(s_edata), .write_addr(s_waddr),
        .write_en(s_we), .busy(s_busy), .done(s_done));

    encrypter #(.KEY(c_KEY), .DEPTH(c_DF), .ADDR_W(c_AW)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(f_start), .plain_data(f_plain),
        .read_addr(f_raddr), .encrypted_data(f_edata), .write_addr(f_waddr),
        .write_en(f_we), .busy(f_busy), .done(f_done));

    encrypter #(.KEY(c_KEY), .DEPTH(c_D1), .ADDR_W(c_AW)) u_dut_one (
        .clk(clk), .rst_n(rst_n), .start(o_start), .plain_data(o_plain),
        .read_addr(o_raddr), .encrypted_data(o_edata), .write_addr(o_waddr),
        .write_en(o_we), .busy(o_busy), .done(o_done));

    // Reference: cipher = plain XOR (KEY XOR low byte of KEY*16), optionally
    // XOR the address modulo 256.
    function automatic logic [7:0] model_cipher(input int a, input logic [7:0] p);
        int k;
        k = int'(c_KEY) ^ ((int'(c_KEY) * 16) % 256);
`ifdef ROLLING_KEY_EN
        k = k ^ (a % 256);
`endif
        return p ^ 8'(k);
    endfunction

    task automatic fill_random(input int n);
        for (int a = 0; a < n; a++) mem[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_raddr, s_waddr, s_edata, s_we, s_busy, s_done} !== '0) begin
            n_fail++; $display("FAIL reset_small: outputs=%h required 0", {s_raddr, s_waddr, s_edata, s_we, s_busy, s_done});
        end
        n_checks++;
        if ({f_raddr, f_waddr, f_edata, f_we, f_busy, f_done} !== '0) begin
            n_fail++; $display("FAIL reset_full: outputs=%h required 0", {f_raddr, f_waddr, f_edata, f_we, f_busy, f_done});
        end
        n_checks++;
        if ({o_raddr, o_waddr, o_edata, o_we, o_busy, o_done} !== '0) begin
            n_fail++; $display("FAIL reset_one: outputs=%h required 0", {o_raddr, o_waddr, o_edata, o_we, o_busy, o_done});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // DEPTH=4, mem[A]=A; also start coincident with done must be ignored.
    task automatic test_small();
        int base, dbase, t0, k, tdone, n, n_bad, bad_i;
        for (int a = 0; a < c_D4; a++) mem[a] = 8'(a);
        base = s_wa.size(); dbase = s_dn;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0; t0 = cycle;
        k = 0;
        @(negedge clk);
        while (s_done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        tdone = cycle;
        s_start = 1'b1;
        n_checks++;
        if (k >= 40) begin n_fail++; $display("FAIL small_timeout: done not seen in %0d cycles", k); end
        n_checks++;
        if (tdone !== t0 + c_D4 + 2) begin n_fail++; $display("FAIL small_done_time: got cycle %0d required %0d", tdone, t0 + c_D4 + 2); end
        n_checks++;
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL small_busy_at_done: got %b required 0", s_busy); end
        @(posedge clk); #1 s_start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL small_start_at_done: busy=%b required 0", s_busy); end
        n_checks++;
        if (s_raddr !== c_AW'(c_D4 - 1)) begin n_fail++; $display("FAIL small_raddr_hold: got %0d required %0d", s_raddr, c_D4 - 1); end
        n = s_wa.size() - base;
        n_checks++;
        if (n !== c_D4) begin n_fail++; $display("FAIL small_write_count: got %0d required %0d", n, c_D4); end
        n_bad = 0; bad_i = -1;
        for (int i = 0; i < n && i < c_D4; i++) begin
            if (s_wa[base+i] !== c_AW'(i) || s_wd[base+i] !== model_cipher(i, mem[i]) || s_wt[base+i] !== t0 + i + 2) begin
                n_bad++; if (bad_i < 0) bad_i = i;
            end
        end
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL small_writes: entry %0d got (addr %0d, data %h, cycle %0d) required (%0d, %h, %0d)",
                     bad_i, s_wa[base+bad_i], s_wd[base+bad_i], s_wt[base+bad_i], bad_i, model_cipher(bad_i, mem[bad_i]), t0 + bad_i + 2);
        end
        n_checks++;
        if (s_dn - dbase !== 1) begin n_fail++; $display("FAIL small_done_count: got %0d required 1", s_dn - dbase); end
    endtask

    task automatic test_full_frame();
        int base, dbase, k, n, n_bad, bad_i;
        fill_random(c_DF);
        base = f_wa.size(); dbase = f_dn;
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        k = 0;
        while (f_done !== 1'b1 && k < c_DF + 20) begin @(negedge clk); k++; end
        n_checks++;
        if (k >= c_DF + 20) begin n_fail++; $display("FAIL full_timeout: done not seen in %0d cycles", k); end
        repeat (3) @(negedge clk);
        n = f_wa.size() - base;
        n_checks++;
        if (n !== c_DF) begin n_fail++; $display("FAIL full_write_count: got %0d required %0d", n, c_DF); end
        n_bad = 0; bad_i = -1;
        for (int i = 0; i < n && i < c_DF; i++) begin
            if (f_wa[base+i] !== c_AW'(i) || f_wd[base+i] !== model_cipher(i, mem[i])) begin
                n_bad++; if (bad_i < 0) bad_i = i;
            end
        end
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL full_data: %0d bad, first entry %0d got (addr %0d, data %h) required (%0d, %h)",
                     n_bad, bad_i, f_wa[base+bad_i], f_wd[base+bad_i], bad_i, model_cipher(bad_i, mem[bad_i]));
        end
        n_checks++;
        if (f_dn - dbase !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d required 1", f_dn - dbase); end
    endtask

    task automatic test_start_while_busy();
        int base, dbase, k, n, n_bad, bad_i;
        fill_random(c_DF);
        base = f_wa.size(); dbase = f_dn;
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        k = 0;
        while (f_wa.size() - base < 100 && k < 200) begin @(negedge clk); k++; end
        f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (f_busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %b required 1", f_busy); end
        k = 0;
        while (f_done !== 1'b1 && k < c_DF + 20) begin @(negedge clk); k++; end
        n_checks++;
        if (k >= c_DF + 20) begin n_fail++; $display("FAIL busy_timeout: done not seen in %0d cycles", k); end
        repeat (5) @(negedge clk);
        n = f_wa.size() - base;
        n_checks++;
        if (n !== c_DF) begin n_fail++; $display("FAIL busy_write_count: got %0d required %0d", n, c_DF); end
        n_bad = 0; bad_i = -1;
        for (int i = 0; i < n && i < c_DF; i++) begin
            if (f_wa[base+i] !== c_AW'(i) || f_wd[base+i] !== model_cipher(i, mem[i])) begin
                n_bad++; if (bad_i < 0) bad_i = i;
            end
        end
        n_checks++;
        if (n_bad !== 0) begin n_fail++; $display("FAIL busy_data: %0d bad, first entry %0d addr %0d", n_bad, bad_i, f_wa[base+bad_i]); end
        n_checks++;
        if (f_dn - dbase !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d required 1", f_dn - dbase); end
        n_checks++;
        if (f_busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got %b required 0", f_busy); end
    endtask

    task automatic test_reset_midpass();
        int base, dbase, k, wcount, n, n_bad, bad_i;
        fill_random(c_DF);
        base = f_wa.size(); dbase = f_dn;
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        k = 0;
        while (f_wa.size() - base < 500 && k < 600) begin @(negedge clk); k++; end
        rst_n = 1'b0;
        #1;
        wcount = f_wa.size();
        n_checks++;
        if ({f_raddr, f_waddr, f_edata, f_we, f_busy, f_done} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h required 0", {f_raddr, f_waddr, f_edata, f_we, f_busy, f_done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (f_wa.size() !== wcount || f_busy !== 1'b0 || f_dn !== dbase) begin
            n_fail++; $display("FAIL midreset_abandon: extra writes %0d busy %b dones %0d required 0/0/0", f_wa.size() - wcount, f_busy, f_dn - dbase);
        end
        fill_random(c_DF);
        base = f_wa.size();
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        k = 0;
        while (f_done !== 1'b1 && k < c_DF + 20) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        n = f_wa.size() - base;
        n_checks++;
        if (n !== c_DF) begin n_fail++; $display("FAIL midreset_repass_count: got %0d required %0d", n, c_DF); end
        n_bad = 0; bad_i = -1;
        for (int i = 0; i < n && i < c_DF; i++) begin
            if (f_wa[base+i] !== c_AW'(i) || f_wd[base+i] !== model_cipher(i, mem[i])) begin
                n_bad++; if (bad_i < 0) bad_i = i;
            end
        end
        n_checks++;
        if (n_bad !== 0) begin n_fail++; $display("FAIL midreset_repass_data: %0d bad, first entry %0d addr %0d", n_bad, bad_i, f_wa[base+bad_i]); end
        n_checks++;
        if (f_dn - dbase !== 1) begin n_fail++; $display("FAIL midreset_done_count: got %0d required 1", f_dn - dbase); end
    endtask

    // All-zero plaintext exposes the raw keystream at chosen addresses.
    task automatic test_key_pattern();
        int base, k;
        logic [7:0] exp5, exp256;
`ifdef ROLLING_KEY_EN
        exp5 = 8'h86; exp256 = 8'h83;
`else
        exp5 = 8'h83; exp256 = 8'h83;
`endif
        for (int a = 0; a < 400; a++) mem[a] = 8'h00;
        base = f_wa.size();
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        k = 0;
        while (f_wa.size() - base < 300 && k < 400) begin @(negedge clk); k++; end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (f_wa.size() - base < 300) begin
            n_fail++; $display("FAIL key_writes: got %0d writes required at least 300", f_wa.size() - base);
        end else begin
            n_checks++;
            if (f_wa[base+5] !== c_AW'(5) || f_wd[base+5] !== exp5) begin
                n_fail++; $display("FAIL key_addr5: got (addr %0d, data %h) required (5, %h)", f_wa[base+5], f_wd[base+5], exp5);
            end
            n_checks++;
            if (f_wa[base+256] !== c_AW'(256) || f_wd[base+256] !== exp256) begin
                n_fail++; $display("FAIL key_addr256: got (addr %0d, data %h) required (256, %h)", f_wa[base+256], f_wd[base+256], exp256);
            end
        end
    endtask

    // DEPTH=1 single write, then a start in the IDLE cycle right after DONE.
    task automatic test_back_to_back();
        int base, dbase, t0, k, tdone;
        mem[0] = 8'($urandom_range(0, 255));
        base = o_wa.size(); dbase = o_dn;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                @(posedge clk); #1 o_start = 1'b1;
            end else begin
                @(posedge clk); #1 o_start = 1'b1;
            end
            @(posedge clk); #1 o_start = 1'b0; t0 = cycle;
            @(negedge clk);
            n_checks++;
            if (o_busy !== 1'b1) begin n_fail++; $display("FAIL one_busy_pass%0d: got %b required 1", pass, o_busy); end
            k = 0;
            while (o_done !== 1'b1 && k < 10) begin @(negedge clk); k++; end
            tdone = cycle;
            n_checks++;
            if (tdone !== t0 + 3) begin n_fail++; $display("FAIL one_done_time_pass%0d: got cycle %0d required %0d", pass, tdone, t0 + 3); end
            n_checks++;
            if (o_wa.size() - base !== pass + 1 || o_wa[base+pass] !== '0 || o_wd[base+pass] !== model_cipher(0, mem[0]) || o_wt[base+pass] !== t0 + 2) begin
                n_fail++;
                $display("FAIL one_write_pass%0d: writes %0d, got (addr %0d, data %h, cycle %0d) required (0, %h, %0d)",
                         pass, o_wa.size() - base, o_wa[base+pass], o_wd[base+pass], o_wt[base+pass], model_cipher(0, mem[0]), t0 + 2);
            end
            n_checks++;
            if (o_busy !== 1'b0) begin n_fail++; $display("FAIL one_busy_at_done_pass%0d: got %b required 0", pass, o_busy); end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_dn - dbase !== 2 || o_wa.size() - base !== 2) begin
            n_fail++; $display("FAIL one_totals: dones %0d writes %0d required 2/2", o_dn - dbase, o_wa.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_back_to_back();
        test_key_pattern();
        test_full_frame();
        test_start_while_busy();
        test_reset_midpass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
